// File: rtl/sw_out_arb_pkg.sv
// Shared constants, state encoding and index helper for the output-port
// switch arbiter and the logic that reuses its round-robin picker.
package sw_out_arb_pkg;

  localparam int NPORT_DEF = 5;
  localparam int NVCH_DEF  = 2;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  // Reset is asserted when rst_ equals this level.
  localparam logic RST_ACT = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sw_out_arb_rr_pick.sv
// Combinational rotate-priority encoder: first set request scanning from ptr
// upward with wrap. Shared with the VC allocator.
module sw_out_arb_rr_pick #(
  parameter int NPORT = 5,
  parameter int IDXW  = 3
) (
  input  logic [NPORT-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [NPORT-1:0] gnt,
  output logic [IDXW-1:0]  idx,
  output logic             vld
);

  logic [IDXW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int k = 0; k < NPORT; k++) begin
      cand = IDXW'((int'(ptr) + k) % NPORT);
      if (!vld && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_out_arb.sv
// Per-output switch arbiter: round-robin among credited head flits, then the
// output stays locked to the winning input until its tail flit is forwarded.
module sw_out_arb
  import sw_out_arb_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int NVCH  = NVCH_DEF,
  parameter int VCHW  = 1,
  localparam int IDXW = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [NPORT-1:0]      req,
  input  logic [NPORT-1:0]      req_head,
  input  logic [NPORT-1:0]      req_tail,
  input  logic [NPORT*VCHW-1:0] req_vch,
  input  logic [NVCH-1:0]       credit_ok,
  output logic [NPORT-1:0]      grant,
  output logic                  grant_vld,
  output logic [VCHW-1:0]       grant_vch,
  output logic                  locked,
  output logic [IDXW-1:0]       owner,
  output logic                  err_proto
);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [VCHW-1:0] lock_vch_q, lock_vch_d;
  logic            err_q, err_d;

  logic [VCHW-1:0]  vch_arr [NPORT];
  logic [NPORT-1:0] elig;
  logic [NPORT-1:0] pick_gnt;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_vld;
  logic [NPORT-1:0] grant_c;
  logic [VCHW-1:0]  gvch_c;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      vch_arr[i] = req_vch[i*VCHW +: VCHW];
      elig[i]    = req[i] & req_head[i] & credit_ok[vch_arr[i]];
    end
  end

  sw_out_arb_rr_pick #(
    .NPORT (NPORT),
    .IDXW  (IDXW)
  ) u_rr_pick (
    .req (elig),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_vch_d = lock_vch_q;
    err_d      = 1'b0;
    grant_c    = '0;
    gvch_c     = '0;
    case (state_q)
      ST_IDLE: begin
        // Body or tail flits with no packet in flight are stray and dropped.
        err_d = |(req & ~req_head);
        if (pick_vld) begin
          grant_c = pick_gnt;
          gvch_c  = vch_arr[pick_idx];
          if (req_tail[pick_idx]) begin
            rr_ptr_d = IDXW'(wrap_inc(int'(pick_idx), NPORT));
          end else begin
            state_d    = ST_LOCKED;
            owner_d    = pick_idx;
            lock_vch_d = vch_arr[pick_idx];
          end
        end
      end
      ST_LOCKED: begin
        gvch_c = lock_vch_q;
        err_d  = req[owner_q] & req_head[owner_q];
        if (req[owner_q] && credit_ok[lock_vch_q]) begin
          grant_c[owner_q] = 1'b1;
          if (req_tail[owner_q]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = IDXW'(wrap_inc(int'(owner_q), NPORT));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_ == RST_ACT) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_vch_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_vch_q <= lock_vch_d;
      err_q      <= err_d;
    end
  end

  assign grant     = (rst_ == RST_ACT) ? '0 : grant_c;
  assign grant_vld = |grant;
  assign grant_vch = (rst_ == RST_ACT) ? '0 : gvch_c;
  assign locked    = (state_q == ST_LOCKED);
  assign owner     = owner_q;
  assign err_proto = err_q;

endmodule

// File: tb/tb_sw_out_arb.sv
// Bench for sw_out_arb: directed scenarios plus a randomized run, all
// compared against a packet-level reference model kept in the bench.
module tb_sw_out_arb;

  localparam int NP = 5;

  logic       clk = 1'b0;
  logic       rst_;
  logic [4:0] req, req_head, req_tail, req_vch;
  logic [1:0] credit_ok;
  logic [4:0] grant;
  logic       grant_vld;
  logic [0:0] grant_vch;
  logic       locked;
  logic [2:0] owner;
  logic       err_proto;

  int checks = 0;
  int errors = 0;

  // Reference model: packet-in-flight flag, owning input, its VC, next start.
  bit         m_locked, n_locked;
  int         m_ptr, m_owner, m_vch, n_ptr, n_owner, n_vch;
  bit         m_err, n_err;
  logic [4:0] exp_grant;
  int         exp_vch;

  always #5 clk = ~clk;

  sw_out_arb dut (
    .clk       (clk),
    .rst_      (rst_),
    .req       (req),
    .req_head  (req_head),
    .req_tail  (req_tail),
    .req_vch   (req_vch),
    .credit_ok (credit_ok),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_vch (grant_vch),
    .locked    (locked),
    .owner     (owner),
    .err_proto (err_proto)
  );

  task automatic model_eval();
    int w;
    exp_grant = '0;
    exp_vch   = 0;
    n_locked  = m_locked;
    n_ptr     = m_ptr;
    n_owner   = m_owner;
    n_vch     = m_vch;
    n_err     = 1'b0;
    if (rst_) begin
      n_locked = 0; n_ptr = 0; n_owner = 0; n_vch = 0;
    end else if (!m_locked) begin
      w = -1;
      for (int i = 0; i < NP; i++)
        if (req[i] && !req_head[i]) n_err = 1'b1;
      for (int k = 0; k < NP; k++) begin
        int i;
        i = (m_ptr + k) % NP;
        if (w < 0 && req[i] && req_head[i] && credit_ok[req_vch[i]]) w = i;
      end
      if (w >= 0) begin
        exp_grant = 5'(1 << w);
        exp_vch   = int'(req_vch[w]);
        if (req_tail[w]) n_ptr = (w + 1) % NP;
        else begin
          n_locked = 1; n_owner = w; n_vch = int'(req_vch[w]);
        end
      end
    end else begin
      exp_vch = m_vch;
      if (req[m_owner] && req_head[m_owner]) n_err = 1'b1;
      if (req[m_owner] && credit_ok[m_vch]) begin
        exp_grant = 5'(1 << m_owner);
        if (req_tail[m_owner]) begin
          n_locked = 0; n_ptr = (m_owner + 1) % NP;
        end
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    m_locked = n_locked; m_ptr = n_ptr; m_owner = n_owner;
    m_vch = n_vch; m_err = n_err;
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t,
                       input logic [4:0] v, input logic [1:0] c);
    req = r; req_head = h; req_tail = t; req_vch = v; credit_ok = c;
  endtask

  task automatic test_reset();
    rst_ = 1'b1;
    drive(5'h1f, 5'h1f, 5'h1f, 5'h00, 2'b11);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (grant !== 5'b0) begin
        errors++; $display("FAIL reset_grant cyc %0d got %b want 00000", c, grant);
      end
      tick();
    end
    checks++;
    if (locked !== 1'b0 || owner !== 3'd0 || err_proto !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got locked=%b owner=%0d err=%b want 0 0 0", locked, owner, err_proto);
    end
  endtask

  task automatic test_single();
    rst_ = 1'b0;
    drive(5'b00001, 5'b00001, 5'b00001, 5'b0, 2'b11);
    #1;
    checks++;
    if (grant !== 5'b00001 || grant_vld !== 1'b1 || grant_vch !== 1'b0) begin
      errors++; $display("FAIL single_grant got %b/%b/%b want 00001/1/0", grant, grant_vld, grant_vch);
    end
    tick();
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL single_locked got %b want 0", locked);
    end
    drive(5'h1f, 5'h1f, 5'h1f, 5'b0, 2'b11);
    #1;
    checks++;
    if (grant !== 5'b00010) begin
      errors++; $display("FAIL single_ptr_advance got %b want 00010", grant);
    end
    tick();
  endtask

  task automatic test_rr_fairness();
    rst_ = 1'b1; tick(); rst_ = 1'b0;
    drive(5'h1f, 5'h1f, 5'h1f, 5'b0, 2'b11);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (grant !== 5'(1 << (c % NP)) || locked !== 1'b0) begin
        errors++; $display("FAIL rr_order cyc %0d got %b want %b", c, grant, 5'(1 << (c % NP)));
      end
      tick();
    end
  endtask

  task automatic test_packet_lock();
    drive(5'b00010, 5'b00010, 5'b00010, 5'b0, 2'b11);
    tick();
    for (int f = 0; f < 4; f++) begin
      drive(5'b00101, (f == 0) ? 5'b00101 : 5'b00001, (f == 3) ? 5'b00101 : 5'b00001,
            5'b00100, 2'b11);
      #1;
      checks++;
      if (grant !== 5'b00100 || grant_vch !== 1'b1) begin
        errors++; $display("FAIL lock_grant flit %0d got %b vch %b want 00100 vch 1", f, grant, grant_vch);
      end
      if (f > 0) begin
        checks++;
        if (locked !== 1'b1 || owner !== 3'd2) begin
          errors++; $display("FAIL lock_owner flit %0d got locked=%b owner=%0d want 1 2", f, locked, owner);
        end
      end
      tick();
    end
    drive(5'b00001, 5'b00001, 5'b00001, 5'b0, 2'b11);
    #1;
    checks++;
    if (grant !== 5'b00001 || locked !== 1'b0) begin
      errors++; $display("FAIL lock_release got %b locked=%b want 00001 0", grant, locked);
    end
    tick();
  endtask

  task automatic test_backpressure();
    drive(5'b01000, 5'b01000, 5'b0, 5'b0, 2'b11);
    #1;
    checks++;
    if (grant !== 5'b01000) begin
      errors++; $display("FAIL bp_head got %b want 01000", grant);
    end
    tick();
    drive(5'b01000, 5'b0, 5'b0, 5'b0, 2'b10);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (grant !== 5'b0 || locked !== 1'b1) begin
        errors++; $display("FAIL bp_stall cyc %0d got %b locked=%b want 00000 1", c, grant, locked);
      end
      tick();
    end
    credit_ok = 2'b11;
    #1;
    checks++;
    if (grant !== 5'b01000) begin
      errors++; $display("FAIL bp_resume got %b want 01000", grant);
    end
    tick();
    req_tail = 5'b01000;
    tick();
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL bp_tail_unlock got %b want 0", locked);
    end
  endtask

  task automatic test_credit_filter();
    rst_ = 1'b1; tick(); rst_ = 1'b0;
    drive(5'b10010, 5'b10010, 5'b10010, 5'b10000, 2'b10);
    #1;
    checks++;
    if (grant !== 5'b10000 || grant_vch !== 1'b1) begin
      errors++; $display("FAIL credit_filter got %b vch %b want 10000 vch 1", grant, grant_vch);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    drive(5'b00010, 5'b00010, 5'b0, 5'b0, 2'b11);
    tick();
    checks++;
    if (locked !== 1'b1 || owner !== 3'd1) begin
      errors++; $display("FAIL rmp_lock got locked=%b owner=%0d want 1 1", locked, owner);
    end
    req_head = 5'b0;
    rst_ = 1'b1;
    #1;
    checks++;
    if (grant !== 5'b0) begin
      errors++; $display("FAIL rmp_grant_in_reset got %b want 00000", grant);
    end
    tick();
    rst_ = 1'b0;
    checks++;
    if (locked !== 1'b0 || owner !== 3'd0) begin
      errors++; $display("FAIL rmp_unlock got locked=%b owner=%0d want 0 0", locked, owner);
    end
    drive(5'h1f, 5'h1f, 5'h1f, 5'b0, 2'b11);
    #1;
    checks++;
    if (grant !== 5'b00001) begin
      errors++; $display("FAIL rmp_ptr_reset got %b want 00001", grant);
    end
    tick();
  endtask

  task automatic test_proto_err();
    drive(5'b00100, 5'b0, 5'b0, 5'b0, 2'b11);
    #1;
    checks++;
    if (grant !== 5'b0) begin
      errors++; $display("FAIL perr_nogrant got %b want 00000", grant);
    end
    tick();
    checks++;
    if (err_proto !== 1'b1) begin
      errors++; $display("FAIL perr_pulse got %b want 1", err_proto);
    end
    drive(5'b0, 5'b0, 5'b0, 5'b0, 2'b11);
    tick();
    checks++;
    if (err_proto !== 1'b0) begin
      errors++; $display("FAIL perr_clear got %b want 0", err_proto);
    end
    drive(5'b00001, 5'b00001, 5'b0, 5'b0, 2'b11);
    tick();
    #1;
    checks++;
    if (grant !== 5'b00001) begin
      errors++; $display("FAIL perr_head_locked_fwd got %b want 00001", grant);
    end
    tick();
    checks++;
    if (err_proto !== 1'b1 || locked !== 1'b1) begin
      errors++; $display("FAIL perr_head_locked got err=%b locked=%b want 1 1", err_proto, locked);
    end
    drive(5'b00001, 5'b0, 5'b00001, 5'b0, 2'b11);
    tick();
    checks++;
    if (err_proto !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL perr_tail got err=%b locked=%b want 0 0", err_proto, locked);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_      = ($urandom_range(0, 79) == 0);
      req       = 5'($urandom);
      req_head  = 5'($urandom) & 5'($urandom);
      req_tail  = 5'($urandom) & 5'($urandom);
      req_vch   = 5'($urandom);
      credit_ok = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      #1;
      model_eval();
      checks++;
      if (grant !== exp_grant || grant_vld !== (exp_grant != 5'b0) ||
          (exp_grant != 5'b0 && grant_vch !== 1'(exp_vch))) begin
        errors++;
        $display("FAIL rand_grant cyc %0d got %b/%b vch %b want %b vch %0d",
                 c, grant, grant_vld, grant_vch, exp_grant, exp_vch);
      end
      checks++;
      if (locked !== m_locked || owner !== 3'(m_owner) || err_proto !== m_err) begin
        errors++;
        $display("FAIL rand_state cyc %0d got locked=%b owner=%0d err=%b want %b %0d %b",
                 c, locked, owner, err_proto, m_locked, m_owner, m_err);
      end
      tick();
    end
  endtask

  initial begin
    rst_ = 1'b1;
    drive(5'b0, 5'b0, 5'b0, 5'b0, 2'b11);
    m_locked = 0; m_ptr = 0; m_owner = 0; m_vch = 0; m_err = 0;
    test_reset();
    test_single();
    test_rr_fairness();
    test_packet_lock();
    test_backpressure();
    test_credit_filter();
    test_reset_mid_packet();
    test_proto_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
